// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - coin credit accumulator with vend strobe and change/refund handshake
module coin_accumulator #(
    parameter int PRICE = 75
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_ready,
    input  logic       cancel,
    output logic [8:0] credit,
    output logic       vend,
    output logic [8:0] change,
    output logic       change_valid,
    input  logic       change_ack
);

    localparam logic [8:0] PRICE_C = 9'(PRICE);

    typedef enum logic {
        COLLECT,
        DISPENSE
    } state_t;

    state_t     state, state_next;
    logic [8:0] credit_next;
    logic [8:0] change_next;
    logic       vend_next;
    logic       change_valid_next;
    logic [8:0] coin_value;
    logic [8:0] sum;

    always_comb begin
        coin_value = 9'd0;
        case (coin_type)
            2'b00:   coin_value = 9'd1;
            2'b01:   coin_value = 9'd5;
            2'b10:   coin_value = 9'd10;
            default: coin_value = 9'd25;
        endcase
    end

    assign sum        = credit + coin_value;
    assign coin_ready = (state == COLLECT) && !cancel && !rst;

    always_comb begin
        state_next        = state;
        credit_next       = credit;
        change_next       = change;
        change_valid_next = change_valid;
        vend_next         = 1'b0;

        case (state)
            COLLECT: begin
                // Cancel with credit refunds through the same change path; cancel also
                // drops coin_ready, so a coin offered alongside it is left unconsumed.
                if (cancel) begin
                    if (credit != 9'd0) begin
                        change_next       = credit;
                        credit_next       = 9'd0;
                        change_valid_next = 1'b1;
                        state_next        = DISPENSE;
                    end
                end else if (coin_valid && coin_ready) begin
                    if (sum < PRICE_C) begin
                        credit_next = sum;
                    end else begin
                        credit_next = 9'd0;
                        vend_next   = 1'b1;
                        if (sum > PRICE_C) begin
                            change_next       = sum - PRICE_C;
                            change_valid_next = 1'b1;
                            state_next        = DISPENSE;
                        end
                    end
                end
            end
            DISPENSE: begin
                if (change_ack) begin
                    change_next       = 9'd0;
                    change_valid_next = 1'b0;
                    state_next        = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLLECT;
            credit       <= 9'd0;
            change       <= 9'd0;
            change_valid <= 1'b0;
            vend         <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            change       <= change_next;
            change_valid <= change_valid_next;
            vend         <= vend_next;
        end
    end

endmodule
